// File: rtl/reminder_timekeeper.sv
// 24-hour timekeeper driven by a 1 Hz divider level, plus a sticky water-reminder countdown.
// Optional snooze support is compiled in with `define REMINDER_SNOOZE_EN.
module reminder_timekeeper #(
  parameter int INTERVAL_MIN = 60,
  parameter int SNOOZE_MIN   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       ack,
  input  logic       snooze,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       remind,
  output logic [6:0] mins_left,
  output logic [1:0] o_dbg_state
);

  localparam logic [6:0] LP_INTERVAL = 7'(INTERVAL_MIN);
  localparam logic [6:0] LP_SNOOZE   = 7'(SNOOZE_MIN);

`ifdef REMINDER_SNOOZE_EN
  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_ALERT  = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_ALERT = 2'd1
  } state_t;
  logic w_unused_snooze;
  assign w_unused_snooze = ^{snooze, LP_SNOOZE};
`endif

  logic       r_tick_d;
  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [5:0] r_seconds;
  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_remind;
  logic       w_remind_nxt;
  logic [6:0] r_mins_left;
  logic [6:0] w_mins_left_nxt;

  logic w_sec_pulse;
  logic w_load_ok;
  logic w_min_carry;

  // r_tick_d resets high so a tick already high at reset release is not an edge.
  assign w_sec_pulse = tick & ~r_tick_d;
  assign w_load_ok   = load & (set_hour <= 5'd23) & (set_min <= 6'd59);
  // A valid load discards the coincident second, so no minute carry either.
  assign w_min_carry = w_sec_pulse & ~w_load_ok & (r_seconds == 6'd59);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_d  <= 1'b1;
      r_hours   <= 5'd0;
      r_minutes <= 6'd0;
      r_seconds <= 6'd0;
    end else begin
      r_tick_d <= tick;
      if (w_load_ok) begin
        r_hours   <= set_hour;
        r_minutes <= set_min;
        r_seconds <= 6'd0;
      end else if (w_sec_pulse) begin
        if (r_seconds == 6'd59) begin
          r_seconds <= 6'd0;
          if (r_minutes == 6'd59) begin
            r_minutes <= 6'd0;
            r_hours   <= (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
          end else begin
            r_minutes <= r_minutes + 6'd1;
          end
        end else begin
          r_seconds <= r_seconds + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_COUNT;
      r_remind    <= 1'b0;
      r_mins_left <= LP_INTERVAL;
    end else begin
      r_state     <= w_state_nxt;
      r_remind    <= w_remind_nxt;
      r_mins_left <= w_mins_left_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remind_nxt    = r_remind;
    w_mins_left_nxt = r_mins_left;
    case (r_state)
      ST_COUNT: begin
        if (w_min_carry) begin
          if (r_mins_left > 7'd1) begin
            w_mins_left_nxt = r_mins_left - 7'd1;
          end else if (r_mins_left == 7'd1) begin
            w_mins_left_nxt = 7'd0;
            w_state_nxt     = ST_ALERT;
            w_remind_nxt    = 1'b1;
          end
        end
      end
      ST_ALERT: begin
        // ack beats both a coincident carry and snooze.
        if (ack) begin
          w_state_nxt     = ST_COUNT;
          w_remind_nxt    = 1'b0;
          w_mins_left_nxt = LP_INTERVAL;
`ifdef REMINDER_SNOOZE_EN
        end else if (snooze) begin
          w_state_nxt     = ST_SNOOZE;
          w_remind_nxt    = 1'b0;
          w_mins_left_nxt = LP_SNOOZE;
`endif
        end else begin
          w_remind_nxt    = 1'b1;
          w_mins_left_nxt = 7'd0;
        end
      end
`ifdef REMINDER_SNOOZE_EN
      ST_SNOOZE: begin
        if (ack) begin
          w_state_nxt     = ST_COUNT;
          w_remind_nxt    = 1'b0;
          w_mins_left_nxt = LP_INTERVAL;
        end else if (w_min_carry) begin
          if (r_mins_left > 7'd1) begin
            w_mins_left_nxt = r_mins_left - 7'd1;
          end else if (r_mins_left == 7'd1) begin
            w_mins_left_nxt = 7'd0;
            w_state_nxt     = ST_ALERT;
            w_remind_nxt    = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_nxt     = ST_COUNT;
        w_remind_nxt    = 1'b0;
        w_mins_left_nxt = LP_INTERVAL;
      end
    endcase
  end

  assign hours       = r_hours;
  assign minutes     = r_minutes;
  assign seconds     = r_seconds;
  assign remind      = r_remind;
  assign mins_left   = r_mins_left;
  assign o_dbg_state = r_state;

endmodule
